// File: rtl/chunked_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : chunked_addsub_if
// Purpose  : Handshake and operand/result bundle for chunked_addsub.
//            Optional Zero signal present when CHUNKED_ADDSUB_ZERO_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface chunked_addsub_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic [WIDTH-1:0] Y;
  logic             Cout;
  logic             Overflow;
  logic             done;
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
  logic             Zero;

  modport master (output start, A, B, Cin, Sub,
                  input  ready, Y, Cout, Overflow, done, Zero);
  modport slave  (input  start, A, B, Cin, Sub,
                  output ready, Y, Cout, Overflow, done, Zero);
`else
  modport master (output start, A, B, Cin, Sub,
                  input  ready, Y, Cout, Overflow, done);
  modport slave  (input  start, A, B, Cin, Sub,
                  output ready, Y, Cout, Overflow, done);
`endif
endinterface
`default_nettype wire

// File: rtl/chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module   : chunked_addsub
// Purpose  : Multi-cycle add/subtract, CHUNK bits per clock, with carry and
//            signed-overflow flags. Define CHUNKED_ADDSUB_ZERO_FLAG_EN for Zero.
// Revision : 1.0 - initial release
// ============================================================================
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic            clk,
  input  logic            rst,
  chunked_addsub_if.slave bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_bx_msb;
  logic [WIDTH-1:0] r_acc;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_y;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_bx_in;

  assign w_accept = bus.start && (r_state != RUN);
  assign w_last   = (r_state == RUN) && (r_idx == c_LAST);
  assign w_bx_in  = bus.Sub ? ~bus.B : bus.B;

  // Operands shift right each cycle, so the active chunk is always the low one.
  assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_bx[CHUNK-1:0]}
               + {{CHUNK{1'b0}}, r_carry};

  // Accumulator fills from the top; after N chunks chunk 0 sits at the bottom.
  if (N == 1) begin : g_single
    assign w_acc_nxt = w_sum[CHUNK-1:0];
  end else begin : g_multi
    assign w_acc_nxt = {w_sum[CHUNK-1:0], r_acc[WIDTH-1:CHUNK]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = bus.start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_bx     <= '0;
      r_carry  <= 1'b0;
      r_a_msb  <= 1'b0;
      r_bx_msb <= 1'b0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_y      <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.A;
      r_bx     <= w_bx_in;
      r_carry  <= bus.Cin ^ bus.Sub;
      r_a_msb  <= bus.A[WIDTH-1];
      r_bx_msb <= w_bx_in[WIDTH-1];
      r_acc    <= '0;
      r_idx    <= '0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> CHUNK;
      r_bx    <= r_bx >> CHUNK;
      r_carry <= w_sum[CHUNK];
      r_acc   <= w_acc_nxt;
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_y    <= w_acc_nxt;
        r_cout <= w_sum[CHUNK];
        r_ovf  <= (r_a_msb == r_bx_msb) && (w_sum[CHUNK-1] != r_a_msb);
      end
    end
  end

`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_zero <= (w_acc_nxt == '0);
    end
  end

  assign bus.Zero = r_zero;
`endif

  assign bus.ready    = (r_state != RUN);
  assign bus.done     = (r_state == DONE);
  assign bus.Y        = r_y;
  assign bus.Cout     = r_cout;
  assign bus.Overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_chunked_addsub
// Purpose  : Self-checking bench for chunked_addsub (WIDTH=32, CHUNK=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_chunked_addsub;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int LAT   = WIDTH / CHUNK;
  localparam longint c_MAXS = 64'sd2147483647;
  localparam longint c_MINS = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  chunked_addsub_if #(.WIDTH(WIDTH)) bus ();

  chunked_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] prev_y = '0;
  logic        prev_c = 1'b0;
  logic        prev_o = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] y;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: exact signed/unsigned integer arithmetic on 64-bit values.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] y, output logic co, output logic ov);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint ci = longint'(cin);
    longint ex;
    if (!sub) begin
      ex = sa + sb + ci;
      co = (ua + ub + ci) > 64'sd4294967295;
      y  = 32'(ua + ub + ci);
    end else begin
      ex = sa - sb - ci;
      co = (ua >= ub + ci);
      y  = 32'(ua - ub - ci);
    end
    ov = (ex > c_MAXS) || (ex < c_MINS);
  endfunction

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub,
                       input logic [31:0] ey, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom;
    lat = 0;
    while (!bus.done && lat < 20) begin
      chk({nm, "_hold"}, bus.Y, prev_y);
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, LAT);
    chk({nm, "_y"}, bus.Y, ey);
    chk({nm, "_cout"}, bus.Cout, ec);
    chk({nm, "_ovf"}, bus.Overflow, eo);
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
    chk({nm, "_zero"}, bus.Zero, (ey == 32'h0));
`endif
    prev_y = ey; prev_c = ec; prev_o = eo;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, bus.ready, 1'b1);
    chk({nm, "_done"}, bus.done, 1'b0);
    chk({nm, "_y"}, bus.Y, 32'h0);
    chk({nm, "_cout"}, bus.Cout, 1'b0);
    chk({nm, "_ovf"}, bus.Overflow, 1'b0);
`ifdef CHUNKED_ADDSUB_ZERO_FLAG_EN
    chk({nm, "_zero"}, bus.Zero, 1'b0);
`endif
  endtask

  initial begin
    logic [31:0] my;
    logic        mc;
    logic        mo;
    int          lat;
    int          seen;
    int          dt[$];

    vecs[0] = '{32'hFFFFFF01, 32'h0000001A, 1'b0, 1'b0, 32'hFFFFFF1B, 1'b0, 1'b0};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h80000001, 1'b0, 1'b1};
    vecs[2] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0};
    vecs[6] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};

    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0;
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
            vecs[i].y, vecs[i].cout, vecs[i].ovf);

    // Asynchronous reset mid-cycle while holding a non-zero result.
    do_op("pre_rst", 32'h12340000, 32'h00005678, 1'b0, 1'b0, 32'h12345678, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    prev_y = '0; prev_c = 1'b0; prev_o = 1'b0;

    // start pulsed and operands changed during RUN must be ignored.
    @(negedge clk);
    bus.A = 32'h12345678; bus.B = 32'h11111111; bus.Cin = 1'b0; bus.Sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.A = 32'h0; bus.B = 32'hFFFFFFFF; bus.Sub = 1'b1; bus.Cin = 1'b1;
    lat = 0;
    @(negedge clk);
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ignore_lat", lat, LAT);
    chk("ignore_y", bus.Y, 32'h23456789);
    chk("ignore_cout", bus.Cout, 1'b0);
    chk("ignore_ovf", bus.Overflow, 1'b0);
    @(negedge clk);
    chk("ignore_idle_done", bus.done, 1'b0);
    chk("ignore_idle_ready", bus.ready, 1'b1);

    // start held high: back-to-back acceptance in the DONE cycle.
    @(negedge clk);
    bus.A = 32'h0F0F0F0F; bus.B = 32'h10101010; bus.Cin = 1'b1; bus.Sub = 1'b1;
    bus.start = 1'b1;
    model(32'h0F0F0F0F, 32'h10101010, 1'b1, 1'b1, my, mc, mo);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dt.push_back(k);
        chk("held_y", bus.Y, my);
      end
    end
    bus.start = 1'b0;
    chk("held_count", dt.size(), 3);
    if (dt.size() > 0) chk("held_first", dt[0], LAT + 1);
    for (int i = 1; i < dt.size(); i++) chk("held_gap", dt[i] - dt[i-1], LAT + 1);
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    chk("held_drain", seen, 1);
    prev_y = my; prev_c = mc; prev_o = mo;

    // Reset two cycles into RUN aborts without a done pulse.
    @(negedge clk);
    bus.A = 32'hDEADBEEF; bus.B = 32'h01010101; bus.Cin = 1'b0; bus.Sub = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort_nodone", seen, 0);
    chk("abort_y", bus.Y, 32'h0);
    prev_y = '0; prev_c = 1'b0; prev_o = 1'b0;

    // Randomized operations against the integer reference.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (i % 5 == 1) rb = ra;
      if (i % 5 == 3) rb = ~ra;
      model(ra, rb, rc, rs, my, mc, mo);
      do_op($sformatf("rnd%0d", i), ra, rb, rc, rs, my, mc, mo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
`default_nettype wire
